// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the
// register-file write path.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    REQ_PIPE,
    REQ_MDU,
    REQ_LSU
  } req_e;

  function automatic logic [NUM_REGS-1:0] addr_dec(
    input logic [REG_ADDR_W-1:0] a
  );
    logic [NUM_REGS-1:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/wport_hold_slot.sv
// One-entry holding register for a secondary write
// producer; optional wait counter (WPORT_ARB_STARVE_EN).
module wport_hold_slot
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
`ifdef WPORT_ARB_STARVE_EN
  , parameter int CNT_W = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  grant,
  output logic                  ready,
  output logic                  valid,
  output logic [REG_ADDR_W-1:0] addr,
  output logic [DATA_W-1:0]     data
`ifdef WPORT_ARB_STARVE_EN
  , output logic [CNT_W-1:0]    age
`endif
);

  logic accept;
  logic keep;

  assign ready  = rstn && (!valid || grant);
  assign accept = in_valid && ready;
  assign keep   = accept && (in_addr != '0);

  // Load on accept (dropping r0 writes), clear on grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (accept) begin
      valid <= keep;
      if (keep) begin
        addr <= in_addr;
        data <= in_data;
      end
    end else if (grant) begin
      valid <= 1'b0;
    end
  end

`ifdef WPORT_ARB_STARVE_EN
  // Count cycles spent waiting; saturate at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      age <= '0;
    end else if (accept || grant || !valid) begin
      age <= '0;
    end else if (age != '1) begin
      age <= age + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/regfile_wport_arb.sv
// Write-port arbiter: pipeline, MDU and LSU share one
// register-file write port. Option: WPORT_ARB_STARVE_EN.
module regfile_wport_arb
  import cpu_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0]     mdu_data,
  output logic                  mdu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0]     lsu_data,
  output logic                  lsu_ready,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]     wdata,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic                  pipe_stall
);

  logic                  m_valid;
  logic [REG_ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0]     m_data;
  logic                  m_gnt;
  logic                  l_valid;
  logic [REG_ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0]     l_data;
  logic                  l_gnt;
  logic                  rr_mdu;
  logic                  pipe_win;
  logic                  both;
  logic                  pick_mdu;
  logic                  do_write;
  req_e                  sel;

`ifdef WPORT_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIM =
    CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] m_age;
  logic [CNT_W-1:0] l_age;
`endif

  wport_hold_slot #(
    .DATA_W(DATA_W)
`ifdef WPORT_ARB_STARVE_EN
    , .CNT_W(CNT_W)
`endif
  ) u_mdu (
    .clk     (clk),
    .rstn    (rstn),
    .in_valid(mdu_valid),
    .in_addr (mdu_addr),
    .in_data (mdu_data),
    .grant   (m_gnt),
    .ready   (mdu_ready),
    .valid   (m_valid),
    .addr    (m_addr),
    .data    (m_data)
`ifdef WPORT_ARB_STARVE_EN
    , .age   (m_age)
`endif
  );

  wport_hold_slot #(
    .DATA_W(DATA_W)
`ifdef WPORT_ARB_STARVE_EN
    , .CNT_W(CNT_W)
`endif
  ) u_lsu (
    .clk     (clk),
    .rstn    (rstn),
    .in_valid(lsu_valid),
    .in_addr (lsu_addr),
    .in_data (lsu_data),
    .grant   (l_gnt),
    .ready   (lsu_ready),
    .valid   (l_valid),
    .addr    (l_addr),
    .data    (l_data)
`ifdef WPORT_ARB_STARVE_EN
    , .age   (l_age)
`endif
  );

  assign pipe_win = wb_en && (wb_addr != '0);
  assign both     = m_valid && l_valid;

`ifdef WPORT_ARB_STARVE_EN
  // While stalling, the longest waiter goes first.
  assign pick_mdu = pipe_stall
    ? ((m_age > l_age) ||
       ((m_age == l_age) && rr_mdu))
    : rr_mdu;
`else
  assign pick_mdu = rr_mdu;

  logic unused_cfg;
  assign unused_cfg = (STARVE_LIMIT != 0);
`endif

  assign m_gnt = !pipe_win && m_valid &&
                 (!l_valid || pick_mdu);
  assign l_gnt = !pipe_win && l_valid &&
                 (!m_valid || !pick_mdu);
  assign do_write = pipe_win || m_gnt || l_gnt;

  // Encode the single winner of this cycle.
  always_comb begin
    sel = REQ_PIPE;
    unique case (1'b1)
      pipe_win: sel = REQ_PIPE;
      m_gnt:    sel = REQ_MDU;
      l_gnt:    sel = REQ_LSU;
      default:  sel = REQ_PIPE;
    endcase
  end

  // Registered write stage to the register file.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_write <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
    end else begin
      reg_write <= do_write;
      if (do_write) begin
        unique case (sel)
          REQ_PIPE: begin
            waddr <= wb_addr;
            wdata <= wb_data;
          end
          REQ_MDU: begin
            waddr <= m_addr;
            wdata <= m_data;
          end
          REQ_LSU: begin
            waddr <= l_addr;
            wdata <= l_data;
          end
          default: ;
        endcase
      end
    end
  end

  // Round-robin moves only on a contended grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_mdu <= 1'b1;
    end else if (both && m_gnt) begin
      rr_mdu <= 1'b0;
    end else if (both && l_gnt) begin
      rr_mdu <= 1'b1;
    end
  end

`ifdef WPORT_ARB_STARVE_EN
  // Request a pipeline bubble for a starving entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_stall <= 1'b0;
    end else begin
      pipe_stall <=
        (m_valid && !m_gnt && (m_age >= LIM)) ||
        (l_valid && !l_gnt && (l_age >= LIM));
    end
  end

  a_no_wb_in_stall : assert property (
    @(posedge clk) disable iff (!rstn)
    !(pipe_stall && wb_en));
`else
  assign pipe_stall = 1'b0;
`endif

  // Destinations buffered or about to be written.
  always_comb begin
    pend_mask = '0;
    if (m_valid) begin
      pend_mask = pend_mask | addr_dec(m_addr);
    end
    if (l_valid) begin
      pend_mask = pend_mask | addr_dec(l_addr);
    end
    if (reg_write) begin
      pend_mask = pend_mask | addr_dec(waddr);
    end
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Scoreboard bench for regfile_wport_arb: expected
// writes queued at drive time, popped on reg_write.
module tb_regfile_wport_arb;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_addr = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_addr = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_ready;
  logic        reg_write;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pend_mask;
  logic        pipe_stall;

  regfile_wport_arb #(
    .DATA_W(32),
    .STARVE_LIMIT(8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .mdu_valid (mdu_valid),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .mdu_ready (mdu_ready),
    .lsu_valid (lsu_valid),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .reg_write (reg_write),
    .waddr     (waddr),
    .wdata     (wdata),
    .pend_mask (pend_mask),
    .pipe_stall(pipe_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input logic [4:0]  a,
    input logic [31:0] d
  );
    sb.push_back('{a: a, d: d});
  endtask

  task automatic wb(
    input logic [4:0]  a,
    input logic [31:0] d
  );
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    if (a != 5'd0) push(a, d);
  endtask

  // Every write leaving the arbiter must match the
  // oldest expected write.
  always @(negedge clk) begin
    if (rstn && reg_write) begin
      if (sb.size() == 0) begin
        check("wr_unexpected", 64'(reg_write), 64'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(waddr), 64'(e.a));
        check("wr_data", 64'(wdata), 64'(e.d));
      end
    end
  end

  initial begin
    int stall_at;

    // reset state
    repeat (3) tick();
    check("rst_reg_write", 64'(reg_write), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_pend", 64'(pend_mask), 64'd0);
    check("rst_stall", 64'(pipe_stall), 64'd0);
    check("rst_mdu_rdy", 64'(mdu_ready), 64'd0);
    check("rst_lsu_rdy", 64'(lsu_ready), 64'd0);
    rstn = 1'b1;
    tick();

    // reset while H_MDU holds r5
    wb(5'd1, 32'h11);
    mdu_valid = 1'b1;
    mdu_addr  = 5'd5;
    mdu_data  = 32'hdead_0005;
    tick();
    mdu_valid = 1'b0;
    wb(5'd2, 32'h22);
    tick();
    check("mid_pend", 64'(pend_mask),
          64'h0000_0024);
    @(negedge clk);
    #1;
    wb_en = 1'b0;
    rstn  = 1'b0;
    #1;
    check("mid_rst_pend", 64'(pend_mask), 64'd0);
    check("mid_rst_rdy", 64'(mdu_ready), 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    check("post_rst_pend", 64'(pend_mask), 64'd0);
    check("post_rst_wr", 64'(reg_write), 64'd0);

    // pipeline only
    wb(5'd3, 32'h1234);
    tick();
    wb_en = 1'b0;
    check("pipe_wr", 64'(reg_write), 64'd1);
    check("pipe_waddr", 64'(waddr), 64'd3);
    check("pipe_wdata", 64'(wdata), 64'h1234);
    wb(5'd0, 32'hffff);
    tick();
    wb_en = 1'b0;
    tick();
    check("wb_r0_nowr", 64'(reg_write), 64'd0);

    // contention: pipeline holds off the MDU
    wb(5'd10, 32'ha0);
    mdu_valid = 1'b1;
    mdu_addr  = 5'd7;
    mdu_data  = 32'h77;
    #1;
    check("cont_rdy0", 64'(mdu_ready), 64'd1);
    tick();
    mdu_valid = 1'b0;
    check("cont_pend7", 64'(pend_mask[7]), 64'd1);
    check("cont_rdy1", 64'(mdu_ready), 64'd0);
    wb(5'd11, 32'ha1);
    tick();
    wb(5'd12, 32'ha2);
    tick();
    wb_en = 1'b0;
    push(5'd7, 32'h77);
    tick();
    check("cont_waddr", 64'(waddr), 64'd7);
    check("cont_pend7b", 64'(pend_mask[7]), 64'd1);
    tick();
    check("cont_pend7c", 64'(pend_mask[7]), 64'd0);

    // round-robin: 8 then 9, then 9 then 8
    for (int r = 0; r < 2; r++) begin
      mdu_valid = 1'b1;
      mdu_addr  = 5'd8;
      mdu_data  = 32'h880 + 32'(r);
      lsu_valid = 1'b1;
      lsu_addr  = 5'd9;
      lsu_data  = 32'h990 + 32'(r);
      #1;
      check("rr_mrdy", 64'(mdu_ready), 64'd1);
      check("rr_lrdy", 64'(lsu_ready), 64'd1);
      if (r == 0) begin
        push(5'd8, 32'h880);
        push(5'd9, 32'h990);
      end else begin
        push(5'd9, 32'h991);
        push(5'd8, 32'h881);
      end
      tick();
      mdu_valid = 1'b0;
      lsu_valid = 1'b0;
      check("rr_pend", 64'(pend_mask[9:8]), 64'd3);
      tick();
      check("rr_first", 64'(waddr),
            (r == 0) ? 64'd8 : 64'd9);
      tick();
      check("rr_second", 64'(waddr),
            (r == 0) ? 64'd9 : 64'd8);
      tick();
    end

    // address 0 from the LSU
    tick();
    lsu_valid = 1'b1;
    lsu_addr  = 5'd0;
    lsu_data  = 32'hbad;
    #1;
    check("a0_rdy", 64'(lsu_ready), 64'd1);
    tick();
    lsu_valid = 1'b0;
    check("a0_pend", 64'(pend_mask), 64'd0);
    check("a0_rdy2", 64'(lsu_ready), 64'd1);
    tick();
    check("a0_nowr", 64'(reg_write), 64'd0);

    // sustained MDU throughput
    for (int i = 0; i < 4; i++) begin
      mdu_valid = 1'b1;
      mdu_addr  = 5'(16 + i);
      mdu_data  = 32'hc0 + 32'(i);
      push(5'(16 + i), 32'hc0 + 32'(i));
      #1;
      check("thru_rdy", 64'(mdu_ready), 64'd1);
      tick();
    end
    mdu_valid = 1'b0;
    repeat (3) tick();

    // starvation: pipeline keeps the LSU waiting
    stall_at = 0;
    wb(5'd20, 32'hb0);
    lsu_valid = 1'b1;
    lsu_addr  = 5'd25;
    lsu_data  = 32'h2525;
    tick();
    lsu_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      wb(5'(20 + (i % 4)), 32'hb0 + 32'(i));
      tick();
      if (pipe_stall && stall_at == 0) begin
        stall_at = i;
        break;
      end
    end
    wb_en = 1'b0;
    push(5'd25, 32'h2525);
`ifdef WPORT_ARB_STARVE_EN
    check("stall_at", 64'(stall_at), 64'd9);
`else
    check("no_stall", 64'(stall_at), 64'd0);
`endif
    tick();
    check("starve_waddr", 64'(waddr), 64'd25);
    check("starve_clr", 64'(pipe_stall), 64'd0);
    repeat (3) tick();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
